// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
//   Oversampling UART receiver. The rx line is synchronised, then a five-state
//   FSM (IDLE, START, DATA, PARITY, STOP) finds the start edge, checks its
//   centre, and takes every later bit by a 2-of-3 majority vote around the
//   bit centre. A good frame is presented on out/valid until it is consumed.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     defined   -> PARITY state and parity_odd input exist, parity_err live
//     undefined -> no parity bit in the frame, parity_err tied to 0
//
// Parameters
//   DATA_WIDTH  data bits per frame (5..9)
//   OVERSAMPLE  clk ticks per bit (even, >= 8)
//   STOP_BITS   stop bits checked (1 or 2)
//
// Ports
//   clk          oversample clock (OVERSAMPLE x baud)
//   rst_n        asynchronous active-low reset
//   en           receiver runs only while high; low aborts a frame
//   in           serial rx line, idle high
//   parity_odd   0 = even, 1 = odd parity (only with UART_RX_PARITY_EN)
//   out          received word, LSB first on the line
//   valid        out holds an unconsumed word
//   ready        consumer takes out when valid && ready
//   busy         high from start detection until back in IDLE
//   frame_err    one-cycle pulse: a stop bit was sampled low
//   parity_err   one-cycle pulse: parity bit mismatch
//   overrun_err  one-cycle pulse: good frame arrived while out was still full
//
// Handshake: out/valid follow valid/ready semantics. Once valid is high, out
// and valid hold until the edge where valid && ready are both high. A word
// completing on that same edge replaces the consumed one and valid stays high.
// -----------------------------------------------------------------------------
module uart_rx_core #(
   parameter int DATA_WIDTH = 8,
   parameter int OVERSAMPLE = 16,
   parameter int STOP_BITS  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  in,
`ifdef UART_RX_PARITY_EN
   input  logic                  parity_odd,
`endif
   output logic [DATA_WIDTH-1:0] out,
   output logic                  valid,
   input  logic                  ready,
   output logic                  busy,
   output logic                  frame_err,
   output logic                  parity_err,
   output logic                  overrun_err
);

   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_WIDTH + 1);

   // The counter restarts at the start edge, so cnt == MID is the start-bit
   // centre. Every later bit centre lands on the same count one bit period on;
   // the vote uses MID-1, MID and MID+1 and is decided at MID+1 (SMP).
   localparam logic [CW-1:0] MID  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] SMP  = CW'(OVERSAMPLE / 2);
   localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t                state, state_n;
   logic [CW-1:0]         cnt, cnt_n;
   logic [BW-1:0]         bit_idx, bit_n;
   logic [DATA_WIDTH-1:0] shreg, shreg_n;
   logic [1:0]            sync_q;
   logic [1:0]            hist;
   logic                  rx_s;
   logic                  maj;
   logic                  good_frame;
   logic                  ferr_n;

   assign rx_s = sync_q[1];
   // hist[0] is rx_s one tick ago, hist[1] two ticks ago.
   assign maj  = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
   assign busy = (state != IDLE);

`ifdef UART_RX_PARITY_EN
   logic par_bad, par_bad_n;
   logic perr_n;
`endif

   // Synchroniser and vote history; both idle at 1 like the line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b11;
         hist   <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], in};
         hist   <= {hist[0], rx_s};
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
`ifdef UART_RX_PARITY_EN
         par_bad <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_idx <= bit_n;
         shreg   <= shreg_n;
`ifdef UART_RX_PARITY_EN
         par_bad <= par_bad_n;
`endif
      end
   end

   // FSM next state
   always_comb begin
      state_n    = state;
      cnt_n      = (cnt == LAST) ? '0 : cnt + 1'b1;
      bit_n      = bit_idx;
      shreg_n    = shreg;
      good_frame = 1'b0;
      ferr_n     = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_n  = par_bad;
      perr_n     = 1'b0;
`endif
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (!rx_s) state_n = START;
         end
         START: begin
            if (cnt == MID) begin
               if (!rx_s) begin
                  state_n = DATA;
                  bit_n   = '0;
`ifdef UART_RX_PARITY_EN
                  par_bad_n = 1'b0;
`endif
               end else begin
                  state_n = IDLE;   // glitch: line back high at start centre
               end
            end
         end
         DATA: begin
            // The first vote after entering DATA falls on the start bit
            // itself (its MID+1 tick); bit_idx 0 swallows it, idx 1..N shift.
            if (cnt == SMP) begin
               if (bit_idx != '0) shreg_n = {maj, shreg[DATA_WIDTH-1:1]};
               if (bit_idx == BW'(DATA_WIDTH)) begin
                  bit_n = '0;
`ifdef UART_RX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end else begin
                  bit_n = bit_idx + 1'b1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt == SMP) begin
               if (maj != (^shreg ^ parity_odd)) begin
                  perr_n    = 1'b1;
                  par_bad_n = 1'b1;
               end
               state_n = STOP;
            end
         end
`endif
         STOP: begin
            // Leaving at the vote (mid-stop) lets a following start edge in.
            if (cnt == SMP) begin
               if (!maj) begin
                  ferr_n  = 1'b1;
                  state_n = IDLE;
               end else if (bit_idx == BW'(STOP_BITS - 1)) begin
                  state_n = IDLE;
`ifdef UART_RX_PARITY_EN
                  good_frame = !par_bad;
`else
                  good_frame = 1'b1;
`endif
               end else begin
                  bit_n = bit_idx + 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // Disable aborts silently; out/valid are untouched by this path.
      if (!en) begin
         state_n    = IDLE;
         good_frame = 1'b0;
         ferr_n     = 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_n     = 1'b0;
`endif
      end
   end

   // Output register, error pulses and consumer handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out         <= '0;
         valid       <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         frame_err   <= ferr_n;
         overrun_err <= 1'b0;
         if (good_frame) begin
            if (valid && !ready) begin
               overrun_err <= 1'b1;   // keep the older word, drop the new one
            end else begin
               out   <= shreg;
               valid <= 1'b1;
            end
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) parity_err <= 1'b0;
      else        parity_err <= perr_n;
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
//   Directed bench for uart_rx_core (DATA_WIDTH=8, OVERSAMPLE=16, STOP_BITS=1).
//   Stimulus pushes each word it expects into exp_q; a monitor pops and
//   compares on every valid && ready handshake and counts error pulses.
//   The parity scenario is compiled only with UART_RX_PARITY_EN.
// -----------------------------------------------------------------------------
module tb_uart_rx_core;

   localparam int DW = 8;
   localparam int OS = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic en = 1'b1;
   logic in = 1'b1;
   logic ready = 1'b1;
`ifdef UART_RX_PARITY_EN
   logic parity_odd = 1'b0;
   logic par_flip = 1'b0;
`endif
   logic [DW-1:0] out;
   logic valid, busy, frame_err, parity_err, overrun_err;

   always #5 clk = ~clk;

   uart_rx_core #(
      .DATA_WIDTH(DW),
      .OVERSAMPLE(OS),
      .STOP_BITS (1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .in         (in),
`ifdef UART_RX_PARITY_EN
      .parity_odd (parity_odd),
`endif
      .out        (out),
      .valid      (valid),
      .ready      (ready),
      .busy       (busy),
      .frame_err  (frame_err),
      .parity_err (parity_err),
      .overrun_err(overrun_err)
   );

   // ---------------- scoreboard state ----------------
   logic [DW-1:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;
   int ferr_cnt = 0, perr_cnt = 0, oerr_cnt = 0, vrise_cnt = 0;
   int b_f = 0, b_p = 0, b_o = 0, b_v = 0;
   logic valid_d = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- monitor ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            valid_d = 1'b0;
         end else begin
            if (frame_err)   ferr_cnt++;
            if (parity_err)  perr_cnt++;
            if (overrun_err) oerr_cnt++;
            if (valid && !valid_d) vrise_cnt++;
            valid_d = valid;
            if (valid && ready) begin
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL rx_word: got 0x%0h, expected no word", out);
               end else begin
                  check("rx_word", out, exp_q.pop_front());
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bit(input logic b);
      in = b;
      tick(OS);
   endtask

   task automatic send_frame(input logic [DW-1:0] d, input logic stop_v);
      send_bit(1'b0);
      for (int i = 0; i < DW; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      send_bit(^d ^ parity_odd ^ par_flip);
`endif
      send_bit(stop_v);
      in = 1'b1;
   endtask

   task automatic mark();
      b_f = ferr_cnt;
      b_p = perr_cnt;
      b_o = oerr_cnt;
      b_v = vrise_cnt;
   endtask

   task automatic expect_counts(input string tag, input int f, input int p, input int o, input int v);
      check({tag, "_frame_err"},   ferr_cnt - b_f, f);
      check({tag, "_parity_err"},  perr_cnt - b_p, p);
      check({tag, "_overrun_err"}, oerr_cnt - b_o, o);
      check({tag, "_valid_rises"}, vrise_cnt - b_v, v);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [DW-1:0] part;

      // reset state
      tick(5);
      check("rst_out", out, 0);
      check("rst_valid", valid, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_parity_err", parity_err, 0);
      check("rst_overrun_err", overrun_err, 0);
      rst_n = 1'b1;
      tick(10);

      // single clean frame
      mark();
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1);
      tick(32);
      expect_counts("a5", 0, 0, 0, 1);

      // start glitch of 4 clks
      mark();
      in = 1'b0;
      tick(4);
      in = 1'b1;
      tick(30);
      check("glitch_busy", busy, 0);
      expect_counts("glitch", 0, 0, 0, 0);

      // stop bit low
      mark();
      send_frame(8'h3C, 1'b0);
      tick(48);
      check("ferr_valid", valid, 0);
      expect_counts("ferr", 1, 0, 0, 0);

      // overrun with consumer stalled
      mark();
      ready = 1'b0;
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      tick(16);
      check("ovr_valid_held", valid, 1);
      check("ovr_out_held", out, 8'h11);
      expect_counts("ovr", 0, 0, 1, 1);
      ready = 1'b1;
      tick(2);
      check("ovr_valid_drop", valid, 0);

      // enable dropped mid-frame
      mark();
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      in = 1'b0;
      tick(8);
      check("en_busy_before", busy, 1);
      en = 1'b0;
      tick(1);
      check("en_busy_after", busy, 0);
      in = 1'b1;
      tick(48);
      en = 1'b1;
      tick(16);
      expect_counts("en_abort", 0, 0, 0, 0);

      // back-to-back boundary words
      mark();
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h81);
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h81, 1'b1);
      tick(32);
      expect_counts("b2b", 0, 0, 0, 3);

      // reset during bit 4 of a frame
      part = 8'hE7;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(part[i]);
      in = part[4];
      tick(8);
      check("mid_rst_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_out", out, 0);
      check("mid_rst_valid", valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_errs", {frame_err, parity_err, overrun_err}, 0);
      in = 1'b1;
      tick(4);
      rst_n = 1'b1;
      tick(20);
      mark();
      exp_q.push_back(8'h5A);
      send_frame(8'h5A, 1'b1);
      tick(32);
      expect_counts("post_rst", 0, 0, 0, 1);

`ifdef UART_RX_PARITY_EN
      // even parity: 0x07 needs parity bit 1; send 0 first
      mark();
      parity_odd = 1'b0;
      par_flip = 1'b1;
      send_frame(8'h07, 1'b1);
      tick(32);
      expect_counts("par_bad", 0, 1, 0, 0);
      mark();
      par_flip = 1'b0;
      exp_q.push_back(8'h07);
      send_frame(8'h07, 1'b1);
      tick(32);
      expect_counts("par_good", 0, 0, 0, 1);
`endif

      check("exp_q_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data bits per frame; the legal range SHALL be 5..9.
REQ-002 Parameter OVERSAMPLE, default 16, clk ticks per bit; it SHALL be an even value of at least 8.
REQ-003 Parameter STOP_BITS, default 1, stop bits checked; it SHALL be 1 or 2.
REQ-004 The port clk SHALL be an input, 1 bit wide, carrying the oversample clock at OVERSAMPLE x baud.
REQ-005 The port rst_n SHALL be an input, 1 bit wide, carrying the asynchronous active-low reset.
REQ-006 The port en SHALL be an input, 1 bit wide; the receiver runs only while it is high.
REQ-007 The port in SHALL be an input, 1 bit wide, carrying the serial rx line (idle high).
REQ-008 The port out SHALL be an output, DATA_WIDTH bits wide, carrying the received word LSB-first.
REQ-009 The port valid SHALL be an output, 1 bit wide, asserted while out holds an unconsumed word.
REQ-010 The port ready SHALL be an input, 1 bit wide; the consumer takes out when valid and ready are both high.
REQ-011 The port busy SHALL be an output, 1 bit wide, high from start detection until return to IDLE.
REQ-012 The ports frame_err, parity_err and overrun_err SHALL each be a 1-bit output that pulses for one clk cycle.
REQ-013 The port parity_odd SHALL be an input, 1 bit wide (0 = even, 1 = odd), present only when UART_RX_PARITY_EN is defined.

Function
REQ-014 in SHALL pass through a 2-flop synchroniser; every decision SHALL use the synchronised value rx_s.
REQ-015 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP; tick counter width SHALL be $clog2(OVERSAMPLE).
REQ-016 IDLE: when rx_s is low, the FSM SHALL go to START with the counter cleared and busy raised.
REQ-017 START: at tick OVERSAMPLE/2-1 the FSM SHALL go to DATA if rx_s is low; otherwise it SHALL return to IDLE with no error (glitch reject).
REQ-018 DATA/PARITY/STOP: each bit SHALL be sampled by 2-of-3 majority of rx_s at ticks mid-1, mid and mid+1, where mid is the bit centre.
REQ-019 DATA SHALL shift in DATA_WIDTH bits LSB-first, then go to PARITY (macro defined) or STOP.
REQ-020 STOP SHALL check STOP_BITS stop bits; on the last stop-bit majority decision it SHALL return to IDLE immediately, so the next start edge is accepted from mid-stop.
REQ-021 A stop bit sampled low SHALL pulse frame_err, discard the word, and return to IDLE.
REQ-022 A good frame SHALL load out and set valid on the clk edge after the final stop decision.
REQ-023 valid SHALL clear on the edge where valid and ready are both high; out SHALL hold its value otherwise.
REQ-024 If a good frame completes while valid is high and ready is low: overrun_err SHALL pulse, the new word SHALL be dropped, and out/valid SHALL be retained.
REQ-025 If a good frame completes in the same cycle that valid and ready are both high: the new word SHALL load, valid SHALL stay high, and no overrun SHALL be flagged.
REQ-026 If en goes low: the FSM SHALL abort to IDLE on the next edge, busy SHALL fall, no error SHALL be flagged, and out/valid SHALL be retained.

Reset
REQ-027 On rst_n low: out=0, valid=0, busy=0, all error outputs=0, state=IDLE, counters=0, synchroniser=1s, asynchronously.
REQ-028 On rst_n low mid-frame, the partial word SHALL be lost; after release, a fresh start edge SHALL be required.

Configuration
REQ-029 With UART_RX_PARITY_EN defined: the PARITY state SHALL check one bit against the XOR of the data bits XOR parity_odd; on mismatch, parity_err SHALL pulse, the word SHALL be dropped, and the stop check SHALL still run.
REQ-030 Without UART_RX_PARITY_EN: no PARITY state, no parity_odd port, and parity_err SHALL be tied to 0.

Verification (DATA_WIDTH=8, OVERSAMPLE=16, STOP_BITS=1 unless noted)
REQ-031 Send 0xA5 at exact baud -> valid rises once with out=0xA5, and no error pulses occur.
REQ-032 Drive in low for 4 clks, then high -> no busy persists past START, no valid, no error.
REQ-033 Send 0x3C with the stop bit forced low -> frame_err pulses once, and valid stays 0.
REQ-034 Send 0x11 then 0x22 with ready=0 -> overrun_err pulses once and out stays 0x11; then ready=1 -> valid drops.
REQ-035 With the macro defined and parity_odd=0, send 0x07 with parity bit 0 -> parity_err pulses and there is no valid; resend with parity bit 1 -> out=0x07.
REQ-036 Assert rst_n low at bit 4 of a frame -> all outputs are 0 immediately, and the next full frame 0x5A is received correctly.
